// File: rtl/wb_conmax_pri_rr_arb.sv
// ---------------------------------------------------------------------------
// wb_conmax_pri_rr_arb
//   Per-slave arbiter for the Wishbone interconnect. One slave port is shared
//   among 8 masters. Each master carries a 2-bit priority. PRI_SEL decides how
//   many levels are honoured: 0 = none (pure round-robin), 1 = bit0 only,
//   2/3 = all four levels. Within the highest requesting level the grant is
//   round-robin. The grant is held until the owner drops its request.
//
//   Optional feature: define WB_CONMAX_ARB_TIMEOUT_EN to add a hold counter
//   that forces re-arbitration after MAX_HOLD busy cycles and pulses timeout_o.
//
// Ports
//   clk_i      in   1   clock, rising edge
//   rst_i      in   1   synchronous active-high reset
//   req_i      in   8   per-master request (cyc)
//   pri_i      in   16  per-master priority, pri_i[2n+1:2n] = master n
//   gnt_o      out  3   granted master index (registered)
//   gnt_vld_o  out  1   grant valid (registered)
//   gnt_oh_o   out  8   one-hot grant, zero when no grant is valid
//   timeout_o  out  1   one-cycle pulse on a forced release (0 without macro)
// ---------------------------------------------------------------------------
module wb_conmax_pri_rr_arb #(
    parameter logic [1:0]  PRI_SEL  = 2'd0,
    parameter int unsigned MAX_HOLD = 256,
    parameter int unsigned HOLD_W   = 8
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [7:0]  req_i,
    input  logic [15:0] pri_i,
    output logic [2:0]  gnt_o,
    output logic        gnt_vld_o,
    output logic [7:0]  gnt_oh_o,
    output logic        timeout_o
);

    // The hold counter must be able to reach MAX_HOLD-1.
    if (MAX_HOLD < 2 || MAX_HOLD > (1 << HOLD_W)) begin : g_bad_hold
        $error("MAX_HOLD must lie in 2..2**HOLD_W");
    end

    typedef enum logic {IDLE, BUSY} state_t;

    state_t          r_state, w_state_nxt;
    logic [2:0]      r_gnt;
    logic [2:0]      r_last;

    logic [7:0][1:0] w_ep;
    logic [7:0]      w_cand;
    logic [7:0]      w_elig;
    logic [1:0]      w_top;
    logic            w_any;
    logic [2:0]      w_win;
    logic            w_force;
    logic            w_load;
    logic [2:0]      w_gnt_nxt;

    // Effective priority per master.
    always_comb begin
        for (int n = 0; n < 8; n++) begin
            if (PRI_SEL == 2'd0)      w_ep[n] = 2'd0;
            else if (PRI_SEL == 2'd1) w_ep[n] = {1'b0, pri_i[2*n]};
            else                      w_ep[n] = pri_i[2*n +: 2];
        end
    end

`ifdef WB_CONMAX_ARB_TIMEOUT_EN
    logic [HOLD_W-1:0] r_hold;
    logic              r_timeout;

    assign w_force   = (r_state == BUSY) && req_i[r_gnt] &&
                       (r_hold == HOLD_W'(MAX_HOLD - 1));
    assign timeout_o = r_timeout;

    // Counts busy cycles of the current owner; any new grant restarts it.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_hold    <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_timeout <= w_force;
            if (w_load)                r_hold <= '0;
            else if (r_state == BUSY)  r_hold <= r_hold + 1'b1;
        end
    end
`else
    assign w_force   = 1'b0;
    assign timeout_o = 1'b0;
`endif

    // A forced release masks the current owner out of the competition.
    assign w_cand = w_force ? (req_i & ~(8'b1 << r_gnt)) : req_i;

    // Highest level present, then round-robin scan starting after r_last.
    always_comb begin
        logic [2:0] idx;
        logic       found;
        w_top = 2'd0;
        for (int n = 0; n < 8; n++)
            if (w_cand[n] && (w_ep[n] > w_top)) w_top = w_ep[n];
        for (int n = 0; n < 8; n++)
            w_elig[n] = w_cand[n] && (w_ep[n] == w_top);
        w_any = |w_elig;
        w_win = r_last;
        found = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            idx = r_last + 3'(k);
            if (!found && w_elig[idx]) begin
                w_win = idx;
                found = 1'b1;
            end
        end
    end

    // Next state / grant load.
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_gnt_nxt   = w_win;
        case (r_state)
            IDLE: begin
                if (w_any) begin
                    w_load      = 1'b1;
                    w_state_nxt = BUSY;
                end
            end
            BUSY: begin
                if (w_force) begin
                    // Nobody else waiting: the owner keeps the bus.
                    w_load    = 1'b1;
                    w_gnt_nxt = w_any ? w_win : r_gnt;
                end else if (!req_i[r_gnt]) begin
                    if (w_any) w_load      = 1'b1;
                    else       w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= IDLE;
            r_gnt   <= 3'd0;
            r_last  <= 3'd7;
        end else begin
            r_state <= w_state_nxt;
            if (w_load) begin
                r_gnt  <= w_gnt_nxt;
                r_last <= w_gnt_nxt;
            end
        end
    end

    assign gnt_o     = r_gnt;
    assign gnt_vld_o = (r_state == BUSY);
    assign gnt_oh_o  = gnt_vld_o ? (8'b1 << r_gnt) : 8'h00;

endmodule

// File: tb/tb_wb_conmax_pri_rr_arb.sv
// ---------------------------------------------------------------------------
// Testbench for wb_conmax_pri_rr_arb. Three instances (PRI_SEL 0, 1, 2) share
// the same request/priority stimulus; a behavioural model follows all three.
// ---------------------------------------------------------------------------
module tb_wb_conmax_pri_rr_arb;

    localparam int MAX_HOLD = 4;
`ifdef WB_CONMAX_ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  req;
    logic [15:0] pri;

    logic [2:0]  g_gnt [3];
    logic        g_vld [3];
    logic [7:0]  g_oh  [3];
    logic        g_to  [3];

    int checks = 0;
    int errors = 0;

    // model state
    int m_gnt [3];
    int m_vld [3];
    int m_last[3];
    int m_hold[3];
    int m_to  [3];

    always #5 clk = ~clk;

    wb_conmax_pri_rr_arb #(.PRI_SEL(2'd0), .MAX_HOLD(MAX_HOLD), .HOLD_W(2)) u_d0 (
        .clk_i(clk), .rst_i(rst), .req_i(req), .pri_i(pri),
        .gnt_o(g_gnt[0]), .gnt_vld_o(g_vld[0]), .gnt_oh_o(g_oh[0]), .timeout_o(g_to[0]));
    wb_conmax_pri_rr_arb #(.PRI_SEL(2'd1), .MAX_HOLD(MAX_HOLD), .HOLD_W(2)) u_d1 (
        .clk_i(clk), .rst_i(rst), .req_i(req), .pri_i(pri),
        .gnt_o(g_gnt[1]), .gnt_vld_o(g_vld[1]), .gnt_oh_o(g_oh[1]), .timeout_o(g_to[1]));
    wb_conmax_pri_rr_arb #(.PRI_SEL(2'd2), .MAX_HOLD(MAX_HOLD), .HOLD_W(2)) u_d2 (
        .clk_i(clk), .rst_i(rst), .req_i(req), .pri_i(pri),
        .gnt_o(g_gnt[2]), .gnt_vld_o(g_vld[2]), .gnt_oh_o(g_oh[2]), .timeout_o(g_to[2]));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Level of master n under a given priority-select mode.
    function automatic int lvl_of(input logic [15:0] p, input int n, input int psel);
        int raw;
        raw = int'((p >> (2 * n)) & 16'h3);
        if (psel == 0) return 0;
        if (psel == 1) return raw % 2;
        return raw;
    endfunction

    // Walk masters in round-robin order after 'last'; the first one seen at
    // the highest level wins. Returns -1 if nobody requests.
    function automatic int pick(input logic [7:0] r, input logic [15:0] p,
                                input int psel, input int last);
        int best, win, n, l;
        best = -1;
        win  = -1;
        for (int k = 1; k <= 8; k++) begin
            n = (last + k) % 8;
            if (r[n]) begin
                l = lvl_of(p, n, psel);
                if (l > best) begin
                    best = l;
                    win  = n;
                end
            end
        end
        return win;
    endfunction

    task automatic give(input int d, input int w);
        m_gnt[d]  = w;
        m_last[d] = w;
        m_vld[d]  = 1;
        m_hold[d] = 0;
    endtask

    task automatic model_step();
        for (int d = 0; d < 3; d++) begin
            int w;
            m_to[d] = 0;
            if (rst) begin
                m_gnt[d] = 0; m_vld[d] = 0; m_last[d] = 7; m_hold[d] = 0;
            end else if (m_vld[d] == 0) begin
                w = pick(req, pri, d, m_last[d]);
                if (w >= 0) give(d, w);
            end else if (req[m_gnt[d]]) begin
                if (TO_EN && m_hold[d] == MAX_HOLD - 1) begin
                    w = pick(req & ~(8'd1 << m_gnt[d]), pri, d, m_last[d]);
                    if (w < 0) w = m_gnt[d];
                    give(d, w);
                    m_to[d] = 1;
                end else begin
                    m_hold[d]++;
                end
            end else begin
                w = pick(req, pri, d, m_last[d]);
                if (w >= 0) give(d, w);
                else        m_vld[d] = 0;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic cmp_model(input int d);
        chk($sformatf("d%0d.gnt", d), 32'(g_gnt[d]), 32'(m_gnt[d]));
        chk($sformatf("d%0d.vld", d), 32'(g_vld[d]), 32'(m_vld[d]));
        chk($sformatf("d%0d.oh", d),  32'(g_oh[d]),
            m_vld[d] != 0 ? (32'd1 << m_gnt[d]) : 32'd0);
        chk($sformatf("d%0d.to", d),  32'(g_to[d]),  32'(m_to[d]));
    endtask

    task automatic do_reset();
        rst = 1'b1; req = 8'h00; pri = 16'h0;
        tick();
        rst = 1'b0;
    endtask

    typedef struct {
        bit          rst;
        logic [7:0]  req;
        logic [15:0] pri;
        int          gnt;
        bit          vld;
        logic [7:0]  oh;
    } vec_t;

    vec_t tbl[13];

    initial begin
        logic [7:0] flip;
        rst = 1'b1; req = 8'h00; pri = 16'h0;

        // Directed table on the 4-level instance (d2).
        tbl[0]  = '{1'b1, 8'h00, 16'h3C04, 0, 1'b0, 8'h00};  // reset
        tbl[1]  = '{1'b0, 8'h62, 16'h3C04, 5, 1'b1, 8'h20};  // 5,6 at level 3
        tbl[2]  = '{1'b0, 8'h62, 16'h3C04, 5, 1'b1, 8'h20};
        tbl[3]  = '{1'b0, 8'h42, 16'h3C04, 6, 1'b1, 8'h40};  // release 5
        tbl[4]  = '{1'b0, 8'h02, 16'h3C04, 1, 1'b1, 8'h02};  // release 6
        tbl[5]  = '{1'b0, 8'h00, 16'h3C04, 1, 1'b0, 8'h00};  // idle
        tbl[6]  = '{1'b0, 8'h04, 16'h0300, 2, 1'b1, 8'h04};  // low-pri owner
        tbl[7]  = '{1'b0, 8'h14, 16'h0300, 2, 1'b1, 8'h04};  // no preempt
        tbl[8]  = '{1'b0, 8'h14, 16'h0300, 2, 1'b1, 8'h04};
        tbl[9]  = '{1'b0, 8'h10, 16'h0300, 4, 1'b1, 8'h10};  // handover
        tbl[10] = '{1'b1, 8'h10, 16'h0300, 0, 1'b0, 8'h00};  // reset mid-grant
        tbl[11] = '{1'b0, 8'h81, 16'h0000, 0, 1'b1, 8'h01};  // master 0 first
        tbl[12] = '{1'b0, 8'h00, 16'h0000, 0, 1'b0, 8'h00};

        for (int i = 0; i < 13; i++) begin
            rst = tbl[i].rst; req = tbl[i].req; pri = tbl[i].pri;
            tick();
            chk($sformatf("tbl%0d.gnt", i), 32'(g_gnt[2]), 32'(tbl[i].gnt));
            chk($sformatf("tbl%0d.vld", i), 32'(g_vld[2]), 32'(tbl[i].vld));
            chk($sformatf("tbl%0d.oh", i),  32'(g_oh[2]),  32'(tbl[i].oh));
            chk($sformatf("tbl%0d.to", i),  32'(g_to[2]),  32'd0);
        end

        // Pure round-robin with all masters requesting.
        do_reset();
        req = 8'hFF;
        tick();
        chk("rr.first", 32'(g_gnt[0]), 32'd0);
        for (int i = 1; i <= 8; i++) begin
            req = ~(8'd1 << ((i - 1) % 8));
            tick();
            chk($sformatf("rr.gnt%0d", i), 32'(g_gnt[0]), 32'(i % 8));
            chk($sformatf("rr.vld%0d", i), 32'(g_vld[0]), 32'd1);
        end

        // Two-level mode uses only pri bit0.
        do_reset();
        pri = 16'h0060; req = 8'h0C;
        tick();
        chk("lvl2.d1", 32'(g_gnt[1]), 32'd3);
        chk("lvl4.d2", 32'(g_gnt[2]), 32'd2);
        chk("lvl0.d0", 32'(g_gnt[0]), 32'd2);

`ifdef WB_CONMAX_ARB_TIMEOUT_EN
        // Forced release after MAX_HOLD busy cycles.
        do_reset();
        req = 8'h08;
        tick();
        chk("to.g3", 32'(g_gnt[0]), 32'd3);
        req = 8'h09;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("to.hold%0d", i), 32'(g_gnt[0]), 32'd3);
            chk($sformatf("to.quiet%0d", i), 32'(g_to[0]), 32'd0);
        end
        tick();
        chk("to.swap_gnt", 32'(g_gnt[0]), 32'd0);
        chk("to.pulse", 32'(g_to[0]), 32'd1);
        tick();
        chk("to.pulse_end", 32'(g_to[0]), 32'd0);
        req = 8'h08;
        tick();
        chk("to.back3", 32'(g_gnt[0]), 32'd3);
        for (int i = 0; i < 3; i++) tick();
        tick();
        chk("to.alone_gnt", 32'(g_gnt[0]), 32'd3);
        chk("to.alone_vld", 32'(g_vld[0]), 32'd1);
        chk("to.alone_pulse", 32'(g_to[0]), 32'd1);
`endif

        // Randomized run against the model.
        do_reset();
        for (int d = 0; d < 3; d++) cmp_model(d);
        for (int c = 0; c < 3000; c++) begin
            flip = 8'($urandom & $urandom & $urandom);
            req  = req ^ flip;
            if ($urandom_range(0, 15) == 0) pri = 16'($urandom);
            rst = ($urandom_range(0, 199) == 0);
            tick();
            for (int d = 0; d < 3; d++) cmp_model(d);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
